gt_lane_loopback_model: RTL

//   Parametrised multi-lane serial-link loopback model for system testbenches.

---
 rtl/gt_lane_loopback_model.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gt_lane_loopback_model.sv
// Multi-lane TX->RX loopback with per-lane delay lines, lane remap, polarity inversion and flush/lock FSM.
// Optional error injection is built when GT_LOOPBACK_ERR_INJECT_EN is defined.
module gt_lane_loopback_model #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  localparam int MAP_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int DLY_W     = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] tx_data,
  input  logic [NUM_LANES-1:0]            tx_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] rx_data,
  output logic [NUM_LANES-1:0]            rx_valid,
  input  logic                            cfg_load,
  input  logic [NUM_LANES*MAP_W-1:0]      cfg_lane_map,
  input  logic [NUM_LANES*DLY_W-1:0]      cfg_delay,
  input  logic [NUM_LANES-1:0]            cfg_invert,
  output logic                            locked,
  output logic                            cfg_error,
  input  logic                            err_inject,
  input  logic [MAP_W-1:0]                err_inject_lane,
  output logic [15:0]                     err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [MAP_W:0] LANE_LIMIT = (MAP_W+1)'(NUM_LANES);

  function automatic logic [NUM_LANES*MAP_W-1:0] identity_map();
    logic [NUM_LANES*MAP_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      m[i*MAP_W +: MAP_W] = MAP_W'(i);
    end
    return m;
  endfunction

  function automatic logic lane_ok(input logic [MAP_W-1:0] lane);
    return ({1'b0, lane} < LANE_LIMIT);
  endfunction

  localparam logic [NUM_LANES*MAP_W-1:0] IDENTITY_MAP = identity_map();

  logic [DATA_WIDTH:0]             buf_r [NUM_LANES][DEPTH];
  logic [DLY_W-1:0]                wr_ptr_r;
  state_t                          state_r, state_nxt_s;
  logic [DLY_W-1:0]                flush_cnt_r, flush_cnt_nxt_s;
  logic [NUM_LANES*MAP_W-1:0]      map_r;
  logic [NUM_LANES*DLY_W-1:0]      delay_r;
  logic [NUM_LANES-1:0]            invert_r;
  logic                            cfg_error_r;
  logic                            map_err_s;
  logic [MAP_W-1:0]                src_s     [NUM_LANES];
  logic [DLY_W-1:0]                dly_s     [NUM_LANES];
  logic [DLY_W-1:0]                rd_addr_s [NUM_LANES];
  logic [DATA_WIDTH-1:0]           rd_data_s [NUM_LANES];
  logic [NUM_LANES-1:0]            rd_valid_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] nxt_data_s;
  logic [NUM_LANES-1:0]            nxt_valid_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_r;
  logic [NUM_LANES-1:0]            rx_valid_r;
  logic                            locked_r;

  // Delay-line storage: every lane written each cycle at the shared pointer, never cleared.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      buf_r[l][wr_ptr_r] <= {tx_valid[l], tx_data[l*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // Flags any incoming map entry that names a lane that does not exist.
  always_comb begin
    map_err_s = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      map_err_s = map_err_s | ~lane_ok(cfg_lane_map[i*MAP_W +: MAP_W]);
    end
  end

  // Flush/lock next-state logic; disable wins, reconfiguration restarts the flush.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    if (!enable) begin
      state_nxt_s     = ST_IDLE;
      flush_cnt_nxt_s = '0;
    end else if (cfg_load && (state_r != ST_IDLE)) begin
      state_nxt_s     = ST_FLUSH;
      flush_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = '0;
        end
        ST_FLUSH: begin
          if (flush_cnt_r == DLY_W'(DEPTH - 1)) begin
            state_nxt_s     = ST_ACTIVE;
            flush_cnt_nxt_s = '0;
          end else begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = flush_cnt_r + DLY_W'(1);
          end
        end
        ST_ACTIVE: begin
          state_nxt_s     = ST_ACTIVE;
          flush_cnt_nxt_s = '0;
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          flush_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Pointer, FSM, shadow configuration and sticky map-error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r    <= '0;
      state_r     <= ST_IDLE;
      flush_cnt_r <= '0;
      map_r       <= IDENTITY_MAP;
      delay_r     <= '0;
      invert_r    <= '0;
      cfg_error_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_r + DLY_W'(1);
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      if (cfg_load) begin
        map_r       <= cfg_lane_map;
        delay_r     <= cfg_delay;
        invert_r    <= cfg_invert;
        cfg_error_r <= cfg_error_r | map_err_s;
      end else begin
        map_r       <= map_r;
        delay_r     <= delay_r;
        invert_r    <= invert_r;
        cfg_error_r <= cfg_error_r;
      end
    end
  end

  // Delay 0 bypasses storage so the freshest word is returned with one register of latency.
  always_comb begin
    rd_valid_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      src_s[i]     = map_r[i*MAP_W +: MAP_W];
      dly_s[i]     = delay_r[i*DLY_W +: DLY_W];
      rd_addr_s[i] = wr_ptr_r - dly_s[i];
      rd_data_s[i] = '0;
      if (!lane_ok(src_s[i])) begin
        rd_valid_s[i] = 1'b0;
        rd_data_s[i]  = '0;
      end else if (dly_s[i] == '0) begin
        rd_valid_s[i] = tx_valid[src_s[i]];
        rd_data_s[i]  = tx_data[src_s[i]*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        {rd_valid_s[i], rd_data_s[i]} = buf_r[src_s[i]][rd_addr_s[i]];
      end
    end
  end

`ifdef GT_LOOPBACK_ERR_INJECT_EN
  logic             armed_r;
  logic [MAP_W-1:0] arm_lane_r;
  logic [15:0]      err_count_r;
  logic             corrupt_s;
`endif

  // Next output words: zero outside ACTIVE, inversion on data only, optional bit-0 corruption.
  always_comb begin
    nxt_data_s  = '0;
    nxt_valid_s = '0;
`ifdef GT_LOOPBACK_ERR_INJECT_EN
    corrupt_s   = 1'b0;
`endif
    if (state_nxt_s == ST_ACTIVE) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        nxt_data_s[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_s[i] ^ {DATA_WIDTH{invert_r[i]}};
        nxt_valid_s[i] = rd_valid_s[i];
      end
`ifdef GT_LOOPBACK_ERR_INJECT_EN
      if (armed_r && rd_valid_s[arm_lane_r]) begin
        corrupt_s = 1'b1;
        nxt_data_s[arm_lane_r*DATA_WIDTH] = ~nxt_data_s[arm_lane_r*DATA_WIDTH];
      end else begin
        corrupt_s = 1'b0;
      end
`endif
    end else begin
      nxt_data_s  = '0;
      nxt_valid_s = '0;
    end
  end

  // Registered outputs; async reset clears them the moment resetn falls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_r  <= '0;
      rx_valid_r <= '0;
      locked_r   <= 1'b0;
    end else begin
      rx_data_r  <= nxt_data_s;
      rx_valid_r <= nxt_valid_s;
      locked_r   <= (state_nxt_s == ST_ACTIVE);
    end
  end

`ifdef GT_LOOPBACK_ERR_INJECT_EN
  // Injection arming and saturating count; arming is dropped whenever the link leaves ACTIVE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed_r     <= 1'b0;
      arm_lane_r  <= '0;
      err_count_r <= 16'd0;
    end else if (corrupt_s) begin
      armed_r     <= 1'b0;
      err_count_r <= (err_count_r == 16'hFFFF) ? 16'hFFFF : err_count_r + 16'd1;
    end else if (state_nxt_s != ST_ACTIVE) begin
      armed_r     <= 1'b0;
    end else if (err_inject && (state_r == ST_ACTIVE) && !armed_r && lane_ok(err_inject_lane)) begin
      armed_r     <= 1'b1;
      arm_lane_r  <= err_inject_lane;
    end else begin
      armed_r     <= armed_r;
      arm_lane_r  <= arm_lane_r;
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`else
  logic unused_inject_s;
  assign unused_inject_s = ^{err_inject, err_inject_lane};
  assign err_count       = 16'd0;
`endif

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign locked    = locked_r;
  assign cfg_error = cfg_error_r;

endmodule
